core_run_controller: RTL and testbench
======================================

// Module: core_run_controller
// PURPOSE
//  Synthesisable run controller for riscv_core; replaces the fixed reset pulse and 10-cycle loop of the bench.
//  Sequences core reset, gates core progress and counts cycles.
//  Snoops the data bus for a write to a TOHOST mailbox and reports pass/fail/timeout.
//  Sits between the top-level clock/reset and riscv_core; shared by simulation benches and FPGA bring-up.
// PARAMETERS
//  RESET_CYCLES  2              cycles core_reset is held high after start
//  MAX_CYCLES    10             run-cycle budget before timeout (>=1)
//  CNT_W         32             width of cycle_count
//  TOHOST_ADDR   32'h0000_0100  mailbox address snooped on bus writes
//  HANG_CYCLES   8              identical-pc cycles that flag a hang (HANG_DETECT_EN only)
// PORTS
//  clock           in   1      single clock, rising edge
//  reset           in   1      asynchronous, active-low; all state cleared while low
//  start           in   1      pulse: begin run from IDLE or DONE (ignored in HOLD/RUN)
//  abort           in   1      return to IDLE from any state next cycle
//  bus_address     in   32     core data-bus address (snooped)
//  bus_write_data  in   32     core data-bus write data (snooped)
//  bus_write       in   1      core data-bus write strobe
//  pc              in   32     core program counter
//  core_reset      out  1      active-high reset to riscv_core
//  core_en         out  1      core clock enable; 1 only in RUN
//  running         out  1      state==RUN
//  done            out  1      state==DONE
//  pass            out  1      run ended on TOHOST write of 32'h1
//  fail            out  1      run ended on TOHOST write != 32'h1
//  timeout         out  1      run ended on cycle budget
//  hang            out  1      run ended on stuck pc (0 without HANG_DETECT_EN)
//  fail_code       out  31     bus_write_data[31:1] captured on fail, else 0
//  cycle_count     out  CNT_W  RUN cycles elapsed, frozen in DONE
// BEHAVIOUR
//  Reset (reset=0)
//   - state=IDLE, core_reset=1, core_en=0.
//   - All flags, fail_code and cycle_count are 0.
//  FSM: IDLE -> HOLD -> RUN -> DONE.
//   - IDLE: core_reset=1, core_en=0; start -> HOLD, with cnt and flags cleared.
//   - HOLD: core_reset=1 for exactly RESET_CYCLES cycles, then RUN.
//   - RUN: core_reset=0, core_en=1; cycle_count += 1 every cycle (saturates at all-ones).
//   - DONE: core_reset=0, core_en=0; outcome flags and cycle_count held; start -> HOLD.
//  RUN exit rules, evaluated each cycle; first match wins:
//   1. bus_write && bus_address==TOHOST_ADDR -> DONE.
//      pass = (data==1); fail = !pass; fail_code = data[31:1] when fail.
//   2. cycle_count+1 == MAX_CYCLES -> DONE, timeout=1.
//   3. HANG_DETECT_EN only: pc stable for HANG_CYCLES consecutive RUN cycles -> DONE, hang=1.
//  Flags are registered, asserted the cycle DONE is entered, and mutually exclusive.
//  A TOHOST write on the final budget cycle reports pass/fail, not timeout.
//  Writes to other addresses, and TOHOST writes outside RUN, are ignored.
//  abort has priority over everything except reset: -> IDLE, flags cleared next cycle.
//  Reset asserted mid-run: immediate IDLE; core_reset=1 asynchronously.
//  start and abort in the same cycle: abort wins.
// CONFIGURATION
//  HANG_DETECT_EN defined:
//   - 32-bit last-pc register plus stall counter, which restarts whenever pc changes.
//   - Exit rule 3 is active.
//  HANG_DETECT_EN undefined: no pc logic, hang tied 0, pc input unused.
// TESTING
//  - Reset: reset=0 -> core_reset=1, core_en=0, all flags 0, cycle_count=0.
//  - Pass: start; TOHOST write of 32'h1 at RUN cycle 4.
//    -> HOLD 2 cycles, DONE, pass=1, cycle_count=4.
//  - Fail: TOHOST write of 32'h7 -> fail=1, fail_code=3, pass=0.
//  - Timeout: no TOHOST write, MAX_CYCLES=10 -> DONE after 10 RUN cycles, timeout=1.
//  - Priority: TOHOST write of 32'h1 on RUN cycle 10 -> pass=1, timeout=0.
//  - Abort/restart: abort mid-RUN -> IDLE; start -> fresh run, cycle_count restarts from 0.
//  - HANG_DETECT_EN: pc held at 32'h20 for 8 cycles -> hang=1.
//    Same stimulus without the macro -> timeout=1.

Source files
------------

// File: rtl/core_run_controller.sv
// Run controller for riscv_core: sequences core reset, gates core progress, counts run cycles,
// and reports pass/fail/timeout from a TOHOST mailbox write. Define HANG_DETECT_EN to add stuck-pc detection.
module core_run_controller #(
  parameter int          RESET_CYCLES = 2,
  parameter int          MAX_CYCLES   = 10,
  parameter int          CNT_W        = 32,
  parameter logic [31:0] TOHOST_ADDR  = 32'h0000_0100,
  parameter int          HANG_CYCLES  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      bus_address,
  input  logic [31:0]      bus_write_data,
  input  logic             bus_write,
  input  logic [31:0]      pc,
  output logic             core_reset,
  output logic             core_en,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic             hang,
  output logic [30:0]      fail_code,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_RUN, ST_DONE} state_t;

  localparam int HOLD_W = (RESET_CYCLES > 2) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((RESET_CYCLES > 0) ? RESET_CYCLES - 1 : 0);

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              budget_hit;
  logic              tohost_hit;
  logic              is_pass;
  logic              hang_hit;

  assign cnt_inc    = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
  assign budget_hit = ({1'b0, cycle_count} + (CNT_W+1)'(1)) == (CNT_W+1)'(MAX_CYCLES);
  assign tohost_hit = bus_write && (bus_address == TOHOST_ADDR);
  assign is_pass    = (bus_write_data == 32'h1);

`ifdef HANG_DETECT_EN
  localparam int HW = $clog2(HANG_CYCLES + 1);

  logic [31:0] last_pc;
  logic [HW-1:0] stall_len;
  logic [HW-1:0] run_len_now;

  // Length of the current identical-pc streak including this cycle; the first RUN cycle starts a new streak.
  always_comb begin
    run_len_now = HW'(1);
    if ((cycle_count != '0) && (pc == last_pc))
      run_len_now = stall_len + HW'(1);
  end

  assign hang_hit = (run_len_now == HW'(HANG_CYCLES));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_pc   <= '0;
      stall_len <= '0;
    end else if (state == ST_RUN) begin
      last_pc   <= pc;
      stall_len <= run_len_now;
    end
  end
`else
  logic unused_pc;
  assign unused_pc = (^pc) ^ (HANG_CYCLES > 0);
  assign hang_hit  = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      core_reset  <= 1'b1;
      core_en     <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      hang        <= 1'b0;
      fail_code   <= '0;
      cycle_count <= '0;
    end else if (abort) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      core_reset  <= 1'b1;
      core_en     <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      hang        <= 1'b0;
      fail_code   <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state       <= ST_HOLD;
            hold_cnt    <= '0;
            core_reset  <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            hang        <= 1'b0;
            fail_code   <= '0;
            cycle_count <= '0;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state      <= ST_RUN;
            core_reset <= 1'b0;
            core_en    <= 1'b1;
            running    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          cycle_count <= cnt_inc;
          // Exit rules in priority order: mailbox write, cycle budget, stuck pc.
          if (tohost_hit || budget_hit || hang_hit) begin
            state   <= ST_DONE;
            core_en <= 1'b0;
            running <= 1'b0;
            done    <= 1'b1;
          end
          if (tohost_hit) begin
            pass      <= is_pass;
            fail      <= !is_pass;
            fail_code <= is_pass ? 31'd0 : bus_write_data[31:1];
          end else if (budget_hit) begin
            timeout <= 1'b1;
          end else if (hang_hit) begin
            hang <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_run_controller.sv
// Self-checking bench for core_run_controller: directed vector table, hand sequences for
// abort/reset corners, and randomized runs checked against a per-cycle scenario model.
module tb_core_run_controller;

  localparam int          RESET_CYCLES = 2;
  localparam int          MAX_CYCLES   = 10;
  localparam int          CNT_W        = 32;
  localparam logic [31:0] TOHOST       = 32'h0000_0100;
  localparam int          HANG_CYCLES  = 8;
  localparam int          NCYC         = 16;

  localparam int K_PASS = 1, K_FAIL = 2, K_TIMEOUT = 3, K_HANG = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [31:0]      bus_address = '0;
  logic [31:0]      bus_write_data = '0;
  logic             bus_write = 1'b0;
  logic [31:0]      pc = '0;
  logic             core_reset, core_en, running, done, pass, fail, timeout, hang;
  logic [30:0]      fail_code;
  logic [CNT_W-1:0] cycle_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-RUN-cycle stimulus of the current scenario, index = RUN cycle number (1-based).
  logic        wr_en   [1:NCYC];
  logic [31:0] wr_addr [1:NCYC];
  logic [31:0] wr_data [1:NCYC];
  logic [31:0] pc_seq  [1:NCYC];

  typedef struct {
    string       name;
    int          wc;
    logic [31:0] addr;
    logic [31:0] data;
    bit          pc_stuck;
    int          exp_kind;
    int          exp_cnt;
    logic [30:0] exp_fc;
  } vec_t;

  core_run_controller #(
    .RESET_CYCLES(RESET_CYCLES), .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W),
    .TOHOST_ADDR(TOHOST), .HANG_CYCLES(HANG_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .bus_address(bus_address), .bus_write_data(bus_write_data), .bus_write(bus_write),
    .pc(pc), .core_reset(core_reset), .core_en(core_en), .running(running), .done(done),
    .pass(pass), .fail(fail), .timeout(timeout), .hang(hang),
    .fail_code(fail_code), .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_scenario();
    for (int k = 1; k <= NCYC; k++) begin
      wr_en[k]   = 1'b0;
      wr_addr[k] = '0;
      wr_data[k] = '0;
      pc_seq[k]  = 32'h1000 + 32'(4 * k);
    end
  endtask

  // Outcome from the rules: scan RUN cycles in order, first cycle with any exit condition wins,
  // ties resolved mailbox > budget > stuck pc.
  task automatic model(output int kind, output int cnt, output logic [30:0] fc);
    kind = 0; cnt = 0; fc = '0;
    for (int k = 1; k <= MAX_CYCLES; k++) begin
      bit stuck;
      stuck = 1'b0;
`ifdef HANG_DETECT_EN
      if (k >= HANG_CYCLES) begin
        stuck = 1'b1;
        for (int j = k - HANG_CYCLES + 1; j <= k; j++)
          if (pc_seq[j] != pc_seq[k]) stuck = 1'b0;
      end
`endif
      if (wr_en[k] && wr_addr[k] == TOHOST) begin
        kind = (wr_data[k] == 32'd1) ? K_PASS : K_FAIL;
        fc   = (kind == K_FAIL) ? wr_data[k][31:1] : 31'd0;
        cnt  = k;
        return;
      end else if (k == MAX_CYCLES) begin
        kind = K_TIMEOUT; cnt = k; return;
      end else if (stuck) begin
        kind = K_HANG; cnt = k; return;
      end
    end
  endtask

  function automatic logic [3:0] kind_flags(input int kind);
    return {kind == K_PASS, kind == K_FAIL, kind == K_TIMEOUT, kind == K_HANG};
  endfunction

  // Start a run from IDLE/DONE, play the scenario arrays, and compare the outcome.
  task automatic run_one(input string name, input int exp_kind, input int exp_cnt, input logic [30:0] exp_fc);
    int hold_seen;
    int end_k;
    hold_seen = 0;
    end_k = 0;
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 20 && !running; i++) begin
      check({name, " hold"}, {core_reset, core_en, done, pass, fail, timeout, hang}, 7'b1000000);
      hold_seen++;
      tick();
    end
    check({name, " hold_len"}, 64'(hold_seen), 64'(RESET_CYCLES));
    for (int k = 1; k <= MAX_CYCLES + 4; k++) begin
      check({name, " run"}, {core_en, core_reset, 32'(cycle_count)}, {2'b10, 32'(k - 1)});
      bus_write      = wr_en[k];
      bus_address    = wr_addr[k];
      bus_write_data = wr_data[k];
      pc             = pc_seq[k];
      tick();
      bus_write = 1'b0;
      if (done) begin
        end_k = k;
        break;
      end
    end
    check({name, " end_cycle"}, 64'(end_k), 64'(exp_cnt));
    check({name, " flags"}, {pass, fail, timeout, hang}, kind_flags(exp_kind));
    check({name, " cycle_count"}, cycle_count, 64'(exp_cnt));
    check({name, " fail_code"}, fail_code, exp_fc);
    check({name, " core_ctl"}, {core_en, core_reset, running}, 3'b000);
    tick();
    check({name, " frozen"}, {done, pass, fail, timeout, hang, 32'(cycle_count)},
          {1'b1, kind_flags(exp_kind), 32'(exp_cnt)});
    $display("%s: kind=%0d cycles=%0d fail_code=%0h", name, exp_kind, exp_cnt, exp_fc);
  endtask

  vec_t vecs[8];

  initial begin
    int kind, cnt;
    logic [30:0] fc;

    vecs[0] = '{"pass4",      4,  TOHOST,       32'h1,         1'b0, K_PASS,    4,  31'd0};
    vecs[1] = '{"fail7",      4,  TOHOST,       32'h7,         1'b0, K_FAIL,    4,  31'd3};
    vecs[2] = '{"timeout",    0,  TOHOST,       32'h1,         1'b0, K_TIMEOUT, 10, 31'd0};
    vecs[3] = '{"pass_last",  10, TOHOST,       32'h1,         1'b0, K_PASS,    10, 31'd0};
    vecs[4] = '{"other_addr", 3,  32'h104,      32'h1,         1'b0, K_TIMEOUT, 10, 31'd0};
    vecs[5] = '{"fail_msb",   1,  TOHOST,       32'h8000_0000, 1'b0, K_FAIL,    1,  31'h4000_0000};
`ifdef HANG_DETECT_EN
    vecs[6] = '{"pc_stuck",   0,  TOHOST,       32'h1,         1'b1, K_HANG,    8,  31'd0};
`else
    vecs[6] = '{"pc_stuck",   0,  TOHOST,       32'h1,         1'b1, K_TIMEOUT, 10, 31'd0};
`endif
    vecs[7] = '{"fail_zero",  9,  TOHOST,       32'h0,         1'b0, K_FAIL,    9,  31'd0};

    // Reset state
    #1;
    check("reset", {core_reset, core_en, running, done, pass, fail, timeout, hang, fail_code, cycle_count},
          {8'b10000000, 31'd0, 32'd0});
    tick(); tick();
    reset = 1'b1;
    tick();
    check("idle", {core_reset, core_en, running, done}, 4'b1000);

    foreach (vecs[i]) begin
      clear_scenario();
      if (vecs[i].pc_stuck)
        for (int k = 1; k <= NCYC; k++) pc_seq[k] = 32'h20;
      if (vecs[i].wc != 0) begin
        wr_en[vecs[i].wc]   = 1'b1;
        wr_addr[vecs[i].wc] = vecs[i].addr;
        wr_data[vecs[i].wc] = vecs[i].data;
      end
      run_one(vecs[i].name, vecs[i].exp_kind, vecs[i].exp_cnt, vecs[i].exp_fc);
    end

    // Abort mid-RUN returns to IDLE with flags cleared
    clear_scenario();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 10 && !running; i++) tick();
    check("abort_reach_run", running, 1'b1);
    tick(); tick();
    abort = 1'b1;
    tick(); abort = 1'b0;
    check("abort_idle", {core_reset, core_en, running, done, pass, fail, timeout, hang}, 8'b10000000);
    $display("abort: state idle");

    // TOHOST write outside RUN is ignored
    bus_write = 1'b1; bus_address = TOHOST; bus_write_data = 32'h1;
    tick(); bus_write = 1'b0;
    check("idle_tohost", {done, pass, running}, 3'b000);

    // start together with abort: abort wins, so no run begins
    start = 1'b1; abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    tick(); tick(); tick();
    check("start_abort", {running, done, core_reset}, 3'b001);
    $display("start+abort: stays idle");

    // Fresh run after abort restarts the count from zero
    clear_scenario();
    wr_en[2] = 1'b1; wr_addr[2] = TOHOST; wr_data[2] = 32'h1;
    run_one("restart", K_PASS, 2, 31'd0);

    // Asynchronous reset mid-run
    clear_scenario();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 10 && !running; i++) tick();
    tick(); tick();
    #3 reset = 1'b0;
    #1;
    check("async_reset", {core_reset, core_en, running, done, 32'(cycle_count)}, {4'b1000, 32'd0});
    $display("async reset: core held in reset");
    tick(); reset = 1'b1;

    // Randomized scenarios against the model
    for (int t = 0; t < 40; t++) begin
      bit slow_pc;
      clear_scenario();
      slow_pc = ($urandom_range(0, 2) == 0);
      pc_seq[1] = $urandom & 32'hFFFF_FFFC;
      for (int k = 2; k <= NCYC; k++)
        pc_seq[k] = (slow_pc && $urandom_range(0, 15) != 0) ? pc_seq[k-1] : pc_seq[k-1] + 32'd4;
      for (int k = 1; k <= NCYC; k++) begin
        if ($urandom_range(0, 5) == 0) begin
          wr_en[k]   = 1'b1;
          wr_addr[k] = ($urandom_range(0, 1) == 0) ? TOHOST : TOHOST + 32'(4 * $urandom_range(1, 8));
          wr_data[k] = ($urandom_range(0, 1) == 0) ? 32'h1 : $urandom;
        end
      end
      model(kind, cnt, fc);
      run_one($sformatf("rand%0d", t), kind, cnt, fc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
